// File: rtl/seq_det_pkg.sv
// Shared types and reset-default configuration for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int   DEF_PATTERN = 'b111;
    localparam int   DEF_LEN     = 3;
    localparam logic DEF_OVERLAP = 1'b0;
    localparam int   DEF_TARGET  = 0;
    localparam int   DEF_WINDOW  = 0;

endpackage

// File: rtl/seq_match_core.sv
// Serial history shifter with a length-masked pattern compare.
// o_hit reflects the bit presented this cycle, before it lands in the history.
module seq_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic               i_din,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_hit
);

    logic [MAX_LEN-1:0] r_history;
    logic [LEN_W-1:0]   r_bitsSeen;
    logic [MAX_LEN-1:0] w_historyNext;
    logic [LEN_W-1:0]   w_bitsSeenNext;
    logic [MAX_LEN-1:0] w_mask;

    always_comb begin
        w_historyNext  = (r_history << 1) | MAX_LEN'(i_din);
        w_bitsSeenNext = (r_bitsSeen >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                         : r_bitsSeen + LEN_W'(1);
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
        o_hit = i_shift && (w_bitsSeenNext >= i_len)
                && (((w_historyNext ^ i_pattern) & w_mask) == '0);
    end

    // Clear wins over shift so a non-overlapping match restarts from zero bits.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_history  <= '0;
            r_bitsSeen <= '0;
        end else if (i_shift) begin
            r_history  <= w_historyNext;
            r_bitsSeen <= w_bitsSeenNext;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the programmable serial pattern detector: config, arming,
// match counting and run termination on target or cycle window.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               start,
    input  logic               abort,
    input  logic               din,
    input  logic               din_valid,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               timeout,
    output logic               cfg_err
);

    state_t             r_state;
    state_t             w_stateNext;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic [WIN_W-1:0]   r_window;

    logic [CNT_W-1:0]   r_matchCount;
    logic [WIN_W-1:0]   r_winCount;
    logic               r_matchPulse;
    logic               r_done;
    logic               r_timeout;
    logic               r_cfgErr;

    logic               w_hit;
    logic               w_lenLegal;
    logic               w_cfgAccept;
    logic               w_cfgErr;
    logic               w_runStart;
    logic               w_matchTake;
    logic               w_doneSet;
    logic               w_timeoutSet;
    logic               w_coreClear;
    logic               w_coreShift;
    logic [CNT_W-1:0]   w_countInc;
    logic [WIN_W-1:0]   w_winInc;

    assign w_lenLegal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_countInc  = (r_matchCount == '1) ? r_matchCount : r_matchCount + CNT_W'(1);
    assign w_winInc    = r_winCount + WIN_W'(1);
    assign w_coreShift = (r_state == RUN) && din_valid;
    assign w_coreClear = w_runStart || (w_matchTake && !r_overlap);

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_coreClear),
        .i_shift   (w_coreShift),
        .i_din     (din),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    // Abort beats both start and a same-cycle match; target beats window expiry.
    always_comb begin
        w_stateNext  = r_state;
        w_cfgAccept  = 1'b0;
        w_cfgErr     = 1'b0;
        w_runStart   = 1'b0;
        w_matchTake  = 1'b0;
        w_doneSet    = 1'b0;
        w_timeoutSet = 1'b0;

        if (cfg_we) begin
            if ((r_state != RUN) && w_lenLegal) w_cfgAccept = 1'b1;
            else                                w_cfgErr    = 1'b1;
        end

        case (r_state)
            IDLE, DONE: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (start) begin
                    w_stateNext = RUN;
                    w_runStart  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else begin
                    w_matchTake = w_hit;
                    if (w_hit && (r_target != '0) && (w_countInc == r_target)) begin
                        w_stateNext = DONE;
                        w_doneSet   = 1'b1;
                    end else if ((r_window != '0) && (w_winInc == r_window)) begin
                        w_stateNext  = DONE;
                        w_timeoutSet = 1'b1;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern    <= MAX_LEN'(DEF_PATTERN);
            r_len        <= LEN_W'(DEF_LEN);
            r_overlap    <= DEF_OVERLAP;
            r_target     <= CNT_W'(DEF_TARGET);
            r_window     <= WIN_W'(DEF_WINDOW);
            r_matchCount <= '0;
            r_winCount   <= '0;
            r_matchPulse <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cfgErr     <= 1'b0;
        end else begin
            r_matchPulse <= w_matchTake;
            r_cfgErr     <= w_cfgErr;
            if (w_cfgAccept) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_target  <= cfg_target;
                r_window  <= cfg_window;
            end
            if (w_runStart) begin
                r_matchCount <= '0;
                r_winCount   <= '0;
                r_done       <= 1'b0;
                r_timeout    <= 1'b0;
            end else begin
                if (r_state == RUN) r_winCount   <= w_winInc;
                if (w_matchTake)    r_matchCount <= w_countInc;
                if (w_doneSet)      r_done       <= 1'b1;
                if (w_timeoutSet)   r_timeout    <= 1'b1;
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign match_pulse = r_matchPulse;
    assign match_count = r_matchCount;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cfg_err     = r_cfgErr;

endmodule
